aes_cipher_iter: RTL and testbench

- Iterative AES encryption engine sitting directly downstream of the key-expansion block.
- Consumes the full expanded schedule w, then encrypts one 128-bit block with one round per clock.
- Uses valid/ready handshakes on input and output, and serves AES-128/192/256 through the same x parameter as key expansion.

---
 rtl/aes_pkg.sv | 37 +++
 rtl/aes_sbox.sv | 37 +++
 rtl/aes_cipher_iter.sv | 130 +++++++++++++
 tb/tb_aes_cipher_iter.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES types, constants and GF(2^8) helpers.
// Used by the iterative cipher and the S-box.
package aes_pkg;

  localparam int RK_W  = 128;
  localparam int BLK_W = 128;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } aes_st_t;

  function automatic int nr(input int k);
    return 10 + 2 * k;
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(
    input logic [7:0] a,
    input logic [7:0] b
  );
    logic [7:0] p;
    logic [7:0] t;
    p = 8'h00;
    t = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ t;
      t = xtime(t);
    end
    return p;
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// Forward AES S-box: GF(2^8) inverse (a^254) then affine map.
// Purely combinational; zero maps to 0x63.
module aes_sbox
  import aes_pkg::*;
(
  input  logic [7:0] a,
  output logic [7:0] s
);

  logic [7:0] p2, p3, p6, p7, p14, p15;
  logic [7:0] p30, p31, p62, p63, p126, p127;
  logic [7:0] inv;

  // addition chain to a^254, the multiplicative inverse
  always_comb begin
    p2   = gmul(a, a);
    p3   = gmul(p2, a);
    p6   = gmul(p3, p3);
    p7   = gmul(p6, a);
    p14  = gmul(p7, p7);
    p15  = gmul(p14, a);
    p30  = gmul(p15, p15);
    p31  = gmul(p30, a);
    p62  = gmul(p31, p31);
    p63  = gmul(p62, a);
    p126 = gmul(p63, p63);
    p127 = gmul(p126, a);
    inv  = gmul(p127, p127);
    s    = inv
         ^ {inv[6:0], inv[7]}
         ^ {inv[5:0], inv[7:6]}
         ^ {inv[4:0], inv[7:5]}
         ^ {inv[3:0], inv[7:4]}
         ^ 8'h63;
  end

endmodule

// File: rtl/aes_cipher_iter.sv
// Iterative AES encryptor, one round per clock, valid/ready on both sides.
// Optional AES_BLK_CNT_EN adds blk_cnt, a count of output handshakes.
module aes_cipher_iter
  import aes_pkg::*;
#(
  parameter int x = 0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [0:RK_W*(11+2*x)-1]   w,
  input  logic [0:BLK_W-1]           in_data,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic [0:BLK_W-1]           out_data,
  output logic                       out_valid,
  input  logic                       out_ready
`ifdef AES_BLK_CNT_EN
  ,
  output logic [31:0]                blk_cnt
`endif
);

  localparam int         NRI = nr(x);
  localparam logic [3:0] NR4 = 4'(NRI);

  aes_st_t state;
  aes_st_t state_nx;

  logic [3:0]       rnd;
  logic [3:0]       ridx;
  logic [0:BLK_W-1] st;
  logic [0:BLK_W-1] sb;
  logic [0:BLK_W-1] sr;
  logic [0:BLK_W-1] mc;
  logic [0:BLK_W-1] rk;
  logic [0:BLK_W-1] nxt;
  logic [7:0]       a0, a1, a2, a3;
  logic             acc;
  logic             hs;
  logic             last;

  assign in_ready = rst_n & (state == IDLE);
  assign acc      = in_valid & in_ready;
  assign hs       = out_valid & out_ready;
  assign last     = (state == RUN) && (rnd == NR4);
  assign ridx     = (state == IDLE) ? 4'd0 : rnd;
  assign rk       = w[RK_W*int'(ridx) +: RK_W];

  for (genvar k = 0; k < 16; k++) begin : g_sb
    aes_sbox u_sbox (
      .a(st[8*k +: 8]),
      .s(sb[8*k +: 8])
    );
  end

  // ShiftRows, MixColumns and AddRoundKey for the current round
  always_comb begin
    sr = '0;
    mc = '0;
    a0 = 8'h00;
    a1 = 8'h00;
    a2 = 8'h00;
    a3 = 8'h00;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        sr[8*(r+4*c) +: 8] = sb[8*(r+4*((c+r)%4)) +: 8];
      end
    end
    for (int c = 0; c < 4; c++) begin
      a0 = sr[8*(4*c+0) +: 8];
      a1 = sr[8*(4*c+1) +: 8];
      a2 = sr[8*(4*c+2) +: 8];
      a3 = sr[8*(4*c+3) +: 8];
      mc[8*(4*c+0) +: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      mc[8*(4*c+1) +: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      mc[8*(4*c+2) +: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      mc[8*(4*c+3) +: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
    nxt = ((rnd == NR4) ? sr : mc) ^ rk;
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // FSM next-state decode
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (acc) state_nx = RUN;
      RUN:     if (rnd == NR4) state_nx = DONE;
      DONE:    if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // round state, round counter and result register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st        <= '0;
      rnd       <= 4'd0;
      out_data  <= '0;
      out_valid <= 1'b0;
    end else if (acc) begin
      st  <= in_data ^ rk;
      rnd <= 4'd1;
    end else if (state == RUN) begin
      st <= nxt;
      if (last) begin
        out_data  <= nxt;
        out_valid <= 1'b1;
      end else begin
        rnd <= rnd + 4'd1;
      end
    end else if (hs) begin
      out_valid <= 1'b0;
    end
  end

`ifdef AES_BLK_CNT_EN
  // completed output handshakes, wraps naturally
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  blk_cnt <= 32'd0;
    else if (hs) blk_cnt <= blk_cnt + 32'd1;
  end
`endif

endmodule

// File: tb/tb_aes_cipher_iter.sv
// Directed bench for aes_cipher_iter with AES-128/192/256 instances.
// Key schedules are expanded locally; ciphertexts are FIPS-197 vectors.
module tb_aes_cipher_iter;

  localparam logic [0:127] P1   = 128'h00112233445566778899aabbccddeeff;
  localparam logic [0:127] P2   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CT_A = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT_B = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] CT_C = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
  localparam logic [127:0] CT_D = 128'h8ea2b7ca516745bfeafc49904b496089;

  logic           clk;
  logic           rst_n;
  logic [0:127]   din;
  logic [2:0]     iv;
  logic [2:0]     ordy;
  logic [2:0]     irdy;
  logic [2:0]     ovld;
  logic [0:127]   od [3];
  logic [0:1407]  w0;
  logic [0:1663]  w1;
  logic [0:1919]  w2;
  logic [0:1919]  tmp;
`ifdef AES_BLK_CNT_EN
  logic [31:0]    bc [3];
`endif

  int nchk;
  int npass;

  aes_cipher_iter #(.x(0)) u0 (
    .clk(clk), .rst_n(rst_n), .w(w0), .in_data(din),
    .in_valid(iv[0]), .in_ready(irdy[0]), .out_data(od[0]),
    .out_valid(ovld[0]), .out_ready(ordy[0])
`ifdef AES_BLK_CNT_EN
    , .blk_cnt(bc[0])
`endif
  );

  aes_cipher_iter #(.x(1)) u1 (
    .clk(clk), .rst_n(rst_n), .w(w1), .in_data(din),
    .in_valid(iv[1]), .in_ready(irdy[1]), .out_data(od[1]),
    .out_valid(ovld[1]), .out_ready(ordy[1])
`ifdef AES_BLK_CNT_EN
    , .blk_cnt(bc[1])
`endif
  );

  aes_cipher_iter #(.x(2)) u2 (
    .clk(clk), .rst_n(rst_n), .w(w2), .in_data(din),
    .in_valid(iv[2]), .in_ready(irdy[2]), .out_data(od[2]),
    .out_valid(ovld[2]), .out_ready(ordy[2])
`ifdef AES_BLK_CNT_EN
    , .blk_cnt(bc[2])
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] bxt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] t = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ t;
      t = bxt(t);
    end
    return p;
  endfunction

  function automatic logic [7:0] sbx(input logic [7:0] b);
    logic [7:0] v = 8'h00;
    for (int y = 1; y < 256; y++)
      if (gm(b, 8'(y)) == 8'h01) v = 8'(y);
    return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]}
             ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] subw(input logic [31:0] t);
    return {sbx(t[31:24]), sbx(t[23:16]), sbx(t[15:8]), sbx(t[7:0])};
  endfunction

  function automatic logic [0:1919] kexp(input logic [0:255] key, input int nk);
    logic [31:0]   wd [60];
    logic [31:0]   t;
    logic [7:0]    rc = 8'h01;
    logic [0:1919] r  = '0;
    int            nw = 4 * (nk + 7);
    for (int i = 0; i < nw; i++) begin
      if (i < nk) begin
        wd[i] = key[32*i +: 32];
      end else begin
        t = wd[i-1];
        if (i % nk == 0) begin
          t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
          rc = bxt(rc);
        end else if (nk > 6 && i % nk == 4) begin
          t = subw(t);
        end
        wd[i] = wd[i-nk] ^ t;
      end
      r[32*i +: 32] = wd[i];
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [127:0] o, input logic [127:0] e);
    nchk++;
    assert (o === e) npass++;
    else $error("FAIL %s observed=%h expected=%h", tag, o, e);
  endtask

  task automatic start(input int i, input logic [0:127] d);
    @(negedge clk);
    din   = d;
    iv[i] = 1'b1;
    chk("in_ready_idle", 128'(irdy[i]), 128'd1);
    @(posedge clk);
    #1;
    iv[i] = 1'b0;
    din   = '1;
    chk("out_valid_after_accept", 128'(ovld[i]), 128'd0);
  endtask

  task automatic wait_out(input int i, input logic [127:0] e, input int lat);
    int n = 1;
    while (!ovld[i] && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("latency", 128'(n), 128'(lat));
    chk("ciphertext", od[i], e);
  endtask

  task automatic handshake(input int i);
    @(negedge clk);
    ordy[i] = 1'b1;
    chk("in_ready_handover", 128'(irdy[i]), 128'd0);
    @(posedge clk);
    #1;
    ordy[i] = 1'b0;
    chk("out_valid_cleared", 128'(ovld[i]), 128'd0);
    chk("in_ready_next", 128'(irdy[i]), 128'd1);
  endtask

  initial begin
    int bad;
    nchk  = 0;
    npass = 0;
    rst_n = 1'b0;
    din   = '0;
    iv    = '0;
    ordy  = '0;
    tmp = kexp({128'h000102030405060708090a0b0c0d0e0f, 128'h0}, 4);
    w0  = tmp[0:1407];
    tmp = kexp({192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0}, 6);
    w1  = tmp[0:1663];
    w2  = kexp(256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f, 8);

    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", 128'(irdy[0]), 128'd0);
    chk("rst_out_valid", 128'(ovld[0]), 128'd0);
    chk("rst_out_data", od[0], 128'd0);
    chk("rst_in_ready_256", 128'(irdy[2]), 128'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("release_in_ready", 128'(irdy[0]), 128'd1);

    start(0, P1);
    wait_out(0, CT_A, 11);
    handshake(0);

    tmp = kexp({128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0}, 4);
    w0  = tmp[0:1407];
    start(0, P2);
    wait_out(0, CT_B, 11);
    handshake(0);

    start(1, P1);
    wait_out(1, CT_C, 13);
    handshake(1);

    start(2, P1);
    wait_out(2, CT_D, 15);
    handshake(2);

    tmp = kexp({128'h000102030405060708090a0b0c0d0e0f, 128'h0}, 4);
    w0  = tmp[0:1407];
    start(0, P1);
    wait_out(0, CT_A, 11);
    bad = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      iv[0] = (k % 2 == 0);
      din   = P2;
      if (irdy[0] !== 1'b0 || ovld[0] !== 1'b1 || od[0] !== CT_A) bad++;
      @(posedge clk);
      #1;
      if (irdy[0] !== 1'b0 || ovld[0] !== 1'b1 || od[0] !== CT_A) bad++;
    end
    iv[0] = 1'b0;
    chk("backpressure_stable", 128'(bad), 128'd0);
    handshake(0);
    repeat (3) @(posedge clk);
    #1;
    chk("no_second_block", 128'(ovld[0]), 128'd0);
`ifdef AES_BLK_CNT_EN
    chk("blk_cnt_three", 128'(bc[0]), 128'd3);
`endif

    start(1, P1);
    wait_out(1, CT_C, 13);
    start(0, P1);
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 128'(ovld[0]), 128'd0);
    chk("midrst_in_ready", 128'(irdy[0]), 128'd0);
    chk("midrst_done_valid", 128'(ovld[1]), 128'd0);
    chk("midrst_done_data", od[1], 128'd0);
`ifdef AES_BLK_CNT_EN
    chk("midrst_blk_cnt", 128'(bc[0]), 128'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("midrst_release_ready", 128'(irdy[0]), 128'd1);
    start(0, P1);
    wait_out(0, CT_A, 11);
    handshake(0);
`ifdef AES_BLK_CNT_EN
    chk("blk_cnt_after_rst", 128'(bc[0]), 128'd1);
`endif

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
